// File: rtl/barcode_rx.sv
// Barcode receiver: decodes the IR sensor's self-clocked serial stream into an
// 8-bit station ID with a sticky valid flag acknowledged by the command processor.
module barcode_rx #(
    parameter int CNT_W = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BC,
    input  logic       clr_ID_vld,
    output logic [7:0] ID,
    output logic       ID_vld
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_LOW,
        S_WAIT_FALL,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       id_q, id_d;
    logic             id_vld_q, id_vld_d;
    logic             bc_s1_q, bc_s2_q, bc_s3_q;

    logic fall;
    logic rise;

    // BC is asynchronous: two flops resolve metastability, the third gives edges.
    assign fall = ~bc_s2_q & bc_s3_q;
    assign rise = bc_s2_q & ~bc_s3_q;

    // NOTE: every variable gets a default at the top of the block, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        id_d      = id_q;
        id_vld_d  = id_vld_q & ~clr_ID_vld;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = CNT_ZERO;
                if (fall) begin
                    state_d = S_START_LOW;
                end
            end

            S_START_LOW: begin
                if (rise) begin
                    period_d  = cnt_q;
                    bit_cnt_d = 4'd0;
                    cnt_d     = CNT_ZERO;
                    state_d   = S_WAIT_FALL;
                end else if (cnt_q == CNT_MAX) begin
                    // Line stuck low: no usable start pulse.
                    cnt_d   = CNT_ZERO;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_WAIT_FALL: begin
                if (fall) begin
                    cnt_d   = CNT_ZERO;
                    state_d = S_SAMPLE;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d   = CNT_ZERO;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_SAMPLE: begin
                // Only the level at the calibrated instant matters; glitches before it are ignored.
                if (cnt_q == period_q) begin
                    shift_d   = {shift_q[6:0], bc_s2_q};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    cnt_d     = CNT_ZERO;
                    state_d   = (bit_cnt_q == 4'd7) ? S_DONE : S_WAIT_FALL;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DONE: begin
                // Station IDs never use the top two bits; anything else is a misread.
                if (shift_q[7:6] == 2'b00) begin
                    id_d     = shift_q;
                    id_vld_d = 1'b1;
                end
                cnt_d   = CNT_ZERO;
                state_d = S_IDLE;
            end

            default: begin
                cnt_d   = CNT_ZERO;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= CNT_ZERO;
            period_q  <= CNT_ZERO;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            id_q      <= 8'h00;
            id_vld_q  <= 1'b0;
            bc_s1_q   <= 1'b1;
            bc_s2_q   <= 1'b1;
            bc_s3_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            id_q      <= id_d;
            id_vld_q  <= id_vld_d;
            bc_s1_q   <= BC;
            bc_s2_q   <= bc_s1_q;
            bc_s3_q   <= bc_s2_q;
        end
    end

    assign ID     = id_q;
    assign ID_vld = id_vld_q;

endmodule

// File: tb/tb_barcode_rx.sv
// Directed bench for barcode_rx: a full-width receiver for the timing cases and an
// 8-bit-counter receiver for the stuck-low abort.
module tb_barcode_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bc_a = 1'b1;
    logic       bc_b = 1'b1;
    logic       clr_a = 1'b0;
    logic       clr_b = 1'b0;
    logic [7:0] id_a, id_b;
    logic       vld_a, vld_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    barcode_rx #(.CNT_W(22)) dut (
        .clk       (clk),
        .rst       (rst),
        .BC        (bc_a),
        .clr_ID_vld(clr_a),
        .ID        (id_a),
        .ID_vld    (vld_a)
    );

    barcode_rx #(.CNT_W(8)) dut_small (
        .clk       (clk),
        .rst       (rst),
        .BC        (bc_b),
        .clr_ID_vld(clr_b),
        .ID        (id_b),
        .ID_vld    (vld_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_bc(input bit sel, input logic v);
        if (sel) bc_b = v;
        else     bc_a = v;
    endtask

    task automatic set_clr(input bit sel, input logic v);
        if (sel) clr_b = v;
        else     clr_a = v;
    endtask

    // One symbol: low for 'low' cycles, then high for the rest of the bit period.
    task automatic drive_pulse(input bit sel, input int low, input int bp);
        set_bc(sel, 1'b0);
        repeat (low) @(negedge clk);
        set_bc(sel, 1'b1);
        repeat (bp - low) @(negedge clk);
    endtask

    // Sends a whole frame starting on a negedge. The 8th sample is taken T+3 posedges
    // after the last falling edge is driven; ID/ID_vld move on the following edge.
    task automatic send_frame(input bit sel, input int t, input int bp, input logic [7:0] data,
                              input bit clr_at_done, input logic pre_vld,
                              input logic [7:0] exp_id, input logic exp_vld, input string tag);
        int low_last;
        drive_pulse(sel, t, bp);
        for (int i = 7; i >= 1; i--) begin
            drive_pulse(sel, data[i] ? t / 2 : (3 * t) / 2, bp);
        end
        low_last = data[0] ? t / 2 : (3 * t) / 2;
        fork
            drive_pulse(sel, low_last, bp);
            begin
                repeat (t + 3) @(posedge clk);
                #1;
                check({tag, "_vld_at_done"}, {31'd0, sel ? vld_b : vld_a}, {31'd0, pre_vld});
                if (clr_at_done) set_clr(sel, 1'b1);
                @(posedge clk);
                #1;
                set_clr(sel, 1'b0);
                check({tag, "_id"}, {24'd0, sel ? id_b : id_a}, {24'd0, exp_id});
                check({tag, "_vld"}, {31'd0, sel ? vld_b : vld_a}, {31'd0, exp_vld});
            end
        join
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_id_a", {24'd0, id_a}, 32'h00);
        check("rst_vld_a", {31'd0, vld_a}, 32'd0);
        check("rst_id_b", {24'd0, id_b}, 32'h00);
        check("rst_vld_b", {31'd0, vld_b}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Basic decode, exact latency, and sticky valid.
        send_frame(1'b0, 500, 1200, 8'h25, 1'b0, 1'b0, 8'h25, 1'b1, "f25");
        repeat (100) @(negedge clk);
        check("f25_hold_vld", {31'd0, vld_a}, 32'd1);
        check("f25_hold_id", {24'd0, id_a}, 32'h25);

        // One-cycle acknowledge.
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check("clr_vld", {31'd0, vld_a}, 32'd0);
        check("clr_id", {24'd0, id_a}, 32'h25);

        // Top bits set: frame dropped.
        send_frame(1'b0, 200, 450, 8'hC5, 1'b0, 1'b0, 8'h25, 1'b0, "fC5");

        // Acknowledge in the DONE cycle: set wins.
        send_frame(1'b0, 200, 450, 8'h12, 1'b1, 1'b0, 8'h12, 1'b1, "f12");

        // Overwrite while valid, then a much shorter T to force period recapture.
        send_frame(1'b0, 1000, 2000, 8'h3F, 1'b0, 1'b1, 8'h3F, 1'b1, "f3F_slow");
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check("clr2_vld", {31'd0, vld_a}, 32'd0);
        send_frame(1'b0, 200, 450, 8'h3F, 1'b0, 1'b0, 8'h3F, 1'b1, "f3F_fast");

        // Reset in the middle of data bit 4 of 0x2A.
        drive_pulse(1'b0, 200, 450);
        drive_pulse(1'b0, 300, 450);
        drive_pulse(1'b0, 300, 450);
        drive_pulse(1'b0, 100, 450);
        bc_a = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_id", {24'd0, id_a}, 32'h00);
        check("mid_rst_vld", {31'd0, vld_a}, 32'd0);
        @(negedge clk);
        bc_a = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send_frame(1'b0, 200, 450, 8'h2A, 1'b0, 1'b0, 8'h2A, 1'b1, "f2A");

        // Stuck-low line on the 8-bit counter receiver, then a normal frame.
        bc_b = 1'b0;
        repeat (300) @(negedge clk);
        check("stuck_vld", {31'd0, vld_b}, 32'd0);
        bc_b = 1'b1;
        repeat (20) @(negedge clk);
        check("stuck_after_vld", {31'd0, vld_b}, 32'd0);
        check("stuck_after_id", {24'd0, id_b}, 32'h00);
        send_frame(1'b1, 40, 100, 8'h07, 1'b0, 1'b0, 8'h07, 1'b1, "f07");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
